// File: rtl/qed_replay_buffer_if.sv
// qed_replay_buffer_if
//   Groups the IFU-side handshake and the QED decoder-side outputs of
//   qed_replay_buffer into one bundle.
//   master : drives ena, exec_dup, stall, ifu_instruction, ifu_valid
//   slave  : drives ifu_ready, ifu_qed_instruction, qed_valid, dup_mode,
//            dup_done, buf_count, buf_full
interface qed_replay_buffer_if #(
  parameter int AW = 4
);
  logic          ena;
  logic          exec_dup;
  logic          stall;
  logic [31:0]   ifu_instruction;
  logic          ifu_valid;
  logic          ifu_ready;
  logic [31:0]   ifu_qed_instruction;
  logic          qed_valid;
  logic          dup_mode;
  logic          dup_done;
  logic [AW:0]   buf_count;
  logic          buf_full;

  modport master (
    output ena, exec_dup, stall, ifu_instruction, ifu_valid,
    input  ifu_ready, ifu_qed_instruction, qed_valid, dup_mode, dup_done,
           buf_count, buf_full
  );

  modport slave (
    input  ena, exec_dup, stall, ifu_instruction, ifu_valid,
    output ifu_ready, ifu_qed_instruction, qed_valid, dup_mode, dup_done,
           buf_count, buf_full
  );
endinterface

// File: rtl/qed_replay_buffer.sv
// qed_replay_buffer
//   Front stage of the QED instruction path. Forwards fetched instructions
//   to the QED decoder (one register stage) and, when enabled, records them
//   in a circular buffer. On exec_dup the recorded words are replayed in
//   program order as the duplicate stream while the IFU is held off.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : qed_replay_buffer_if.slave (IFU handshake + decoder outputs)
//
// state | meaning
// ORIG  | forward IFU instructions, record them when ena is high
// DUP   | replay buffered instructions, IFU blocked
module qed_replay_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  qed_replay_buffer_if.slave bus
);

  localparam logic [31:0]   NOP      = 32'h0000_0013;
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {ORIG = 1'b0, DUP = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic [31:0]   out_q;
  logic          valid_q, dup_mode_q, dup_done_q;

  logic          buf_full_w, start_dup, ready_w, wr_en, rd_en;

  assign buf_full_w = (count_q == CNT_FULL);
  assign start_dup  = bus.ena && bus.exec_dup && (count_q != '0);

  always_comb begin
    state_d = state_q;
    ready_w = 1'b0;
    case (state_q)
      ORIG: begin
        // Fetch is blocked in the entry cycle so that cycle emits a NOP.
        ready_w = !bus.stall && !start_dup && !(bus.ena && buf_full_w);
        if (start_dup && !bus.stall) state_d = DUP;
      end
      DUP: begin
        if (!bus.stall && count_q == CNT_ONE) state_d = ORIG;
      end
      default: state_d = ORIG;
    endcase
  end

  // ready_w is only ever high in ORIG with no stall.
  assign wr_en = bus.ifu_valid && ready_w && bus.ena;
  assign rd_en = (state_q == DUP) && !bus.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ORIG;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.ifu_instruction;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      out_q      <= NOP;
      valid_q    <= 1'b0;
      dup_mode_q <= 1'b0;
      dup_done_q <= 1'b0;
    end else if (!bus.stall) begin
      if (wr_en) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        count_q <= count_q + CNT_ONE;
      end else if (rd_en) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        count_q <= count_q - CNT_ONE;
      end

      if (state_q == DUP) begin
        out_q      <= mem[rd_ptr];
        valid_q    <= 1'b1;
        dup_done_q <= (count_q == CNT_ONE);
      end else if (bus.ifu_valid && ready_w) begin
        out_q      <= bus.ifu_instruction;
        valid_q    <= 1'b1;
        dup_done_q <= 1'b0;
      end else begin
        out_q      <= NOP;
        valid_q    <= 1'b0;
        dup_done_q <= 1'b0;
      end

      // Stays high one edge past DUP exit so it covers the last replayed word.
      dup_mode_q <= (state_q == DUP) || (state_d == DUP);
    end
  end

  assign bus.ifu_ready           = ready_w;
  assign bus.ifu_qed_instruction = out_q;
  assign bus.qed_valid           = valid_q;
  assign bus.dup_mode            = dup_mode_q;
  assign bus.dup_done            = dup_done_q;
  assign bus.buf_count           = count_q;
  assign bus.buf_full            = buf_full_w;

endmodule
